// File: rtl/servant_mem_sched_pkg.sv
// Shared encodings and the round-robin helper for the servant memory scheduler.
package servant_mem_sched_pkg;

  localparam logic [1:0] GNT_IBUS = 2'd0;
  localparam logic [1:0] GNT_DBUS = 2'd1;
  localparam logic [1:0] GNT_EXT  = 2'd2;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  // Next index in the three-entry ring; unused code 3 folds back to IBUS.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx >= GNT_EXT) ? GNT_IBUS : idx + 2'd1;
  endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// Combinational three-way round-robin picker, scanning from the entry after last_i.
module servant_rr_pick (
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] gnt_o,
  output logic       any_o
);
  import servant_mem_sched_pkg::*;

  logic [1:0] c0, c1, c2;

  always_comb begin
    c0    = rr_next(last_i);
    c1    = rr_next(c0);
    c2    = rr_next(c1);
    gnt_o = c0;
    if (req_i[c0]) begin
      gnt_o = c0;
    end else if (req_i[c1]) begin
      gnt_o = c1;
    end else if (req_i[c2]) begin
      gnt_o = c2;
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/servant_mem_sched.sv
// Shares one servant_ram port between ibus, dbus and an external port: one transaction
// at a time, round-robin grant, a dead cycle after each completion and an ack timeout.
module servant_mem_sched #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [AW-1:0] i_ibus_adr,
  input  logic          i_ibus_cyc,
  output logic [31:0]   o_ibus_rdt,
  output logic          o_ibus_ack,
  input  logic [AW-1:0] i_dbus_adr,
  input  logic [31:0]   i_dbus_dat,
  input  logic [3:0]    i_dbus_sel,
  input  logic          i_dbus_we,
  input  logic          i_dbus_cyc,
  output logic [31:0]   o_dbus_rdt,
  output logic          o_dbus_ack,
  input  logic [AW-1:0] i_ext_adr,
  input  logic [31:0]   i_ext_dat,
  input  logic [3:0]    i_ext_sel,
  input  logic          i_ext_we,
  input  logic          i_ext_cyc,
  output logic [31:0]   o_ext_rdt,
  output logic          o_ext_ack,
  output logic [AW-1:0] o_mem_adr,
  output logic [31:0]   o_mem_dat,
  output logic [3:0]    o_mem_sel,
  output logic          o_mem_we,
  output logic          o_mem_cyc,
  input  logic [31:0]   i_mem_rdt,
  input  logic          i_mem_ack,
  output logic          o_err
);
  import servant_mem_sched_pkg::*;

  localparam int unsigned CntW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(TLast);

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] pick_gnt;
  logic       pick_any;
  logic       gnt_cyc;
  logic       busy;
  logic       done_ack;
  logic       timeout;

  servant_rr_pick u_pick (
    .req_i  ({i_ext_cyc, i_dbus_cyc, i_ibus_cyc}),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .any_o  (pick_any)
  );

  always_comb begin
    case (gnt_q)
      GNT_IBUS: gnt_cyc = i_ibus_cyc;
      GNT_DBUS: gnt_cyc = i_dbus_cyc;
      GNT_EXT:  gnt_cyc = i_ext_cyc;
      default:  gnt_cyc = 1'b0;
    endcase
    busy     = (state_q == S_BUSY);
    done_ack = busy & gnt_cyc & i_mem_ack;
    timeout  = (TIMEOUT != 0) && busy && gnt_cyc && !i_mem_ack && (cnt_q == CntLast);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      gnt_q   <= GNT_IBUS;
      last_q  <= GNT_EXT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        // Abort, ack and timeout all forfeit the turn and pass through the dead cycle.
        if (!gnt_cyc || done_ack || timeout) begin
          state_d = S_IDLE;
          last_d  = gnt_q;
          cnt_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_mem_adr  = '0;
    o_mem_dat  = '0;
    o_mem_sel  = '0;
    o_mem_we   = 1'b0;
    o_mem_cyc  = 1'b0;
    o_ibus_ack = 1'b0;
    o_dbus_ack = 1'b0;
    o_ext_ack  = 1'b0;
    o_ibus_rdt = '0;
    o_dbus_rdt = '0;
    o_ext_rdt  = '0;
    o_err      = timeout;
    if (busy) begin
      o_mem_cyc = gnt_cyc;
      case (gnt_q)
        GNT_IBUS: begin
          o_mem_adr = i_ibus_adr;
          o_mem_sel = 4'hf;
        end
        GNT_DBUS: begin
          o_mem_adr = i_dbus_adr;
          o_mem_dat = i_dbus_dat;
          o_mem_sel = i_dbus_sel;
          o_mem_we  = i_dbus_we;
        end
        GNT_EXT: begin
          o_mem_adr = i_ext_adr;
          o_mem_dat = i_ext_dat;
          o_mem_sel = i_ext_sel;
          o_mem_we  = i_ext_we;
        end
        default: ;
      endcase
      if (done_ack || timeout) begin
        case (gnt_q)
          GNT_IBUS: begin
            o_ibus_ack = 1'b1;
            o_ibus_rdt = timeout ? 32'h0 : i_mem_rdt;
          end
          GNT_DBUS: begin
            o_dbus_ack = 1'b1;
            o_dbus_rdt = timeout ? 32'h0 : i_mem_rdt;
          end
          GNT_EXT: begin
            o_ext_ack = 1'b1;
            o_ext_rdt = timeout ? 32'h0 : i_mem_rdt;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servant_mem_sched.sv
// Directed bench for servant_mem_sched: per-cycle vector table plus timeout and reset sequences.
module tb_servant_mem_sched;

  logic        i_clk, i_rst;
  logic [31:0] i_ibus_adr, i_dbus_adr, i_ext_adr;
  logic        i_ibus_cyc, i_dbus_cyc, i_ext_cyc;
  logic [31:0] i_dbus_dat, i_ext_dat;
  logic [3:0]  i_dbus_sel, i_ext_sel;
  logic        i_dbus_we, i_ext_we;
  logic [31:0] o_ibus_rdt, o_dbus_rdt, o_ext_rdt;
  logic        o_ibus_ack, o_dbus_ack, o_ext_ack;
  logic [31:0] o_mem_adr, o_mem_dat;
  logic [3:0]  o_mem_sel;
  logic        o_mem_we, o_mem_cyc;
  logic [31:0] i_mem_rdt;
  logic        i_mem_ack;
  logic        o_err;

  int n_run  = 0;
  int n_fail = 0;

  servant_mem_sched #(.AW(32), .TIMEOUT(15)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ibus_adr (i_ibus_adr),
    .i_ibus_cyc (i_ibus_cyc),
    .o_ibus_rdt (o_ibus_rdt),
    .o_ibus_ack (o_ibus_ack),
    .i_dbus_adr (i_dbus_adr),
    .i_dbus_dat (i_dbus_dat),
    .i_dbus_sel (i_dbus_sel),
    .i_dbus_we  (i_dbus_we),
    .i_dbus_cyc (i_dbus_cyc),
    .o_dbus_rdt (o_dbus_rdt),
    .o_dbus_ack (o_dbus_ack),
    .i_ext_adr  (i_ext_adr),
    .i_ext_dat  (i_ext_dat),
    .i_ext_sel  (i_ext_sel),
    .i_ext_we   (i_ext_we),
    .i_ext_cyc  (i_ext_cyc),
    .o_ext_rdt  (o_ext_rdt),
    .o_ext_ack  (o_ext_ack),
    .o_mem_adr  (o_mem_adr),
    .o_mem_dat  (o_mem_dat),
    .o_mem_sel  (o_mem_sel),
    .o_mem_we   (o_mem_we),
    .o_mem_cyc  (o_mem_cyc),
    .i_mem_rdt  (i_mem_rdt),
    .i_mem_ack  (i_mem_ack),
    .o_err      (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // cyc / e_ack bit order: {ext, dbus, ibus}
  typedef struct packed {
    logic [2:0]  cyc;
    logic        ack;
    logic [31:0] rdt;
    logic        e_cyc;
    logic [31:0] e_adr;
    logic        e_we;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic [2:0]  e_ack;
  } vec_t;

  localparam int NVec = 26;
  vec_t vecs [NVec];

  // port: 0 = memory side idle (all zero), 1 = ibus, 2 = dbus, 3 = ext muxed out.
  function automatic vec_t mk(input logic [2:0] cyc, input logic ack, input logic [31:0] rdt,
                              input logic e_cyc, input int port, input logic [2:0] e_ack);
    vec_t r;
    r.cyc   = cyc;
    r.ack   = ack;
    r.rdt   = rdt;
    r.e_cyc = e_cyc;
    r.e_ack = e_ack;
    r.e_adr = 32'h0;
    r.e_we  = 1'b0;
    r.e_sel = 4'h0;
    r.e_dat = 32'h0;
    case (port)
      1: begin r.e_adr = 32'h10; r.e_sel = 4'hf; end
      2: begin r.e_adr = 32'h20; r.e_we = 1'b1; r.e_sel = 4'b0011; r.e_dat = 32'hdeadbeef; end
      3: begin r.e_adr = 32'h30; r.e_sel = 4'hf; r.e_dat = 32'h12345678; end
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] cyc, input logic ack, input logic [31:0] rdt);
    i_ibus_cyc = cyc[0];
    i_dbus_cyc = cyc[1];
    i_ext_cyc  = cyc[2];
    i_mem_ack  = ack;
    i_mem_rdt  = rdt;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  initial begin
    i_rst      = 1'b1;
    i_ibus_adr = 32'h10;
    i_dbus_adr = 32'h20;
    i_ext_adr  = 32'h30;
    i_dbus_dat = 32'hdeadbeef;
    i_dbus_sel = 4'b0011;
    i_dbus_we  = 1'b1;
    i_ext_dat  = 32'h12345678;
    i_ext_sel  = 4'hf;
    i_ext_we   = 1'b0;
    drive(3'b111, 1'b1, 32'hcafef00d);

    vecs[0]  = mk(3'b001, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[1]  = mk(3'b001, 1'b0, 32'h0,  1'b1, 1, 3'b000);
    vecs[2]  = mk(3'b001, 1'b1, 32'h13, 1'b1, 1, 3'b001);
    vecs[3]  = mk(3'b000, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[4]  = mk(3'b111, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[5]  = mk(3'b111, 1'b0, 32'h0,  1'b1, 2, 3'b000);
    vecs[6]  = mk(3'b111, 1'b1, 32'h55, 1'b1, 2, 3'b010);
    vecs[7]  = mk(3'b111, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[8]  = mk(3'b111, 1'b0, 32'h0,  1'b1, 3, 3'b000);
    vecs[9]  = mk(3'b111, 1'b1, 32'h66, 1'b1, 3, 3'b100);
    vecs[10] = mk(3'b111, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[11] = mk(3'b111, 1'b0, 32'h0,  1'b1, 1, 3'b000);
    vecs[12] = mk(3'b111, 1'b1, 32'h77, 1'b1, 1, 3'b001);
    vecs[13] = mk(3'b011, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[14] = mk(3'b011, 1'b0, 32'h0,  1'b1, 2, 3'b000);
    vecs[15] = mk(3'b011, 1'b1, 32'h5a, 1'b1, 2, 3'b010);
    vecs[16] = mk(3'b001, 1'b1, 32'h88, 1'b0, 0, 3'b000);
    vecs[17] = mk(3'b001, 1'b0, 32'h0,  1'b1, 1, 3'b000);
    vecs[18] = mk(3'b001, 1'b1, 32'h99, 1'b1, 1, 3'b001);
    vecs[19] = mk(3'b100, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[20] = mk(3'b100, 1'b0, 32'h0,  1'b1, 3, 3'b000);
    vecs[21] = mk(3'b000, 1'b1, 32'haa, 1'b0, 3, 3'b000);
    vecs[22] = mk(3'b011, 1'b0, 32'h0,  1'b0, 0, 3'b000);
    vecs[23] = mk(3'b011, 1'b0, 32'h0,  1'b1, 1, 3'b000);
    vecs[24] = mk(3'b001, 1'b1, 32'h13, 1'b1, 1, 3'b001);
    vecs[25] = mk(3'b000, 1'b0, 32'h0,  1'b0, 0, 3'b000);

    #1;
    chk("rst mem_cyc", 32'(o_mem_cyc), 32'h0);
    chk("rst mem_adr", o_mem_adr, 32'h0);
    chk("rst acks", 32'({o_ext_ack, o_dbus_ack, o_ibus_ack}), 32'h0);
    chk("rst ibus_rdt", o_ibus_rdt, 32'h0);
    chk("rst err", 32'(o_err), 32'h0);

    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].cyc, vecs[i].ack, vecs[i].rdt);
      #1;
      chk($sformatf("v%0d mem_cyc", i), 32'(o_mem_cyc), 32'(vecs[i].e_cyc));
      chk($sformatf("v%0d mem_adr", i), o_mem_adr, vecs[i].e_adr);
      chk($sformatf("v%0d mem_we", i), 32'(o_mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_sel", i), 32'(o_mem_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d mem_dat", i), o_mem_dat, vecs[i].e_dat);
      chk($sformatf("v%0d acks", i), 32'({o_ext_ack, o_dbus_ack, o_ibus_ack}),
          32'(vecs[i].e_ack));
      chk($sformatf("v%0d ibus_rdt", i), o_ibus_rdt, vecs[i].e_ack[0] ? vecs[i].rdt : 32'h0);
      chk($sformatf("v%0d dbus_rdt", i), o_dbus_rdt, vecs[i].e_ack[1] ? vecs[i].rdt : 32'h0);
      chk($sformatf("v%0d ext_rdt", i), o_ext_rdt, vecs[i].e_ack[2] ? vecs[i].rdt : 32'h0);
      chk($sformatf("v%0d err", i), 32'(o_err), 32'h0);
      next_cycle();
    end

    // Timeout: ext granted, memory silent, dbus queued behind it.
    drive(3'b100, 1'b0, 32'hffffffff);
    #1;
    chk("tmo idle mem_cyc", 32'(o_mem_cyc), 32'h0);
    next_cycle();
    for (int k = 1; k <= 15; k++) begin
      drive(3'b110, 1'b0, 32'hffffffff);
      #1;
      chk($sformatf("tmo%0d mem_cyc", k), 32'(o_mem_cyc), 32'h1);
      chk($sformatf("tmo%0d ext_ack", k), 32'(o_ext_ack), 32'(k == 15));
      chk($sformatf("tmo%0d err", k), 32'(o_err), 32'(k == 15));
      chk($sformatf("tmo%0d ext_rdt", k), o_ext_rdt, 32'h0);
      chk($sformatf("tmo%0d dbus_ack", k), 32'(o_dbus_ack), 32'h0);
      next_cycle();
    end
    #1;
    chk("tmo dead mem_cyc", 32'(o_mem_cyc), 32'h0);
    chk("tmo dead err", 32'(o_err), 32'h0);
    next_cycle();
    #1;
    chk("tmo next mem_cyc", 32'(o_mem_cyc), 32'h1);
    chk("tmo next mem_adr", o_mem_adr, 32'h20);
    drive(3'b010, 1'b1, 32'hffffffff);
    #1;
    chk("tmo next dbus_ack", 32'(o_dbus_ack), 32'h1);
    chk("tmo next dbus_rdt", o_dbus_rdt, 32'hffffffff);
    chk("tmo next ext_ack", 32'(o_ext_ack), 32'h0);
    next_cycle();

    // Asynchronous reset in the middle of a dbus transaction.
    drive(3'b010, 1'b0, 32'h0);
    next_cycle();
    #1;
    chk("rstmid busy mem_cyc", 32'(o_mem_cyc), 32'h1);
    chk("rstmid busy mem_adr", o_mem_adr, 32'h20);
    i_mem_ack = 1'b1;
    i_mem_rdt = 32'h1234;
    #1;
    chk("rstmid pre dbus_ack", 32'(o_dbus_ack), 32'h1);
    i_rst = 1'b1;
    #1;
    chk("rstmid mem_cyc", 32'(o_mem_cyc), 32'h0);
    chk("rstmid dbus_ack", 32'(o_dbus_ack), 32'h0);
    chk("rstmid dbus_rdt", o_dbus_rdt, 32'h0);
    chk("rstmid mem_adr", o_mem_adr, 32'h0);
    chk("rstmid mem_we", 32'(o_mem_we), 32'h0);
    chk("rstmid err", 32'(o_err), 32'h0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(3'b011, 1'b0, 32'h0);
    #1;
    chk("rstpost idle mem_cyc", 32'(o_mem_cyc), 32'h0);
    next_cycle();
    #1;
    chk("rstpost mem_cyc", 32'(o_mem_cyc), 32'h1);
    chk("rstpost mem_adr", o_mem_adr, 32'h10);
    chk("rstpost mem_we", 32'(o_mem_we), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
